bloke2_stream_driver: RTL

- Host-side master for the bloke2 hash core byte-stream interface.
- Buffers a message written by the host, then drives the core input side: start pulse, din byte stream with din_end, finish pulse.
- Collects the core output stream (dout/dout_valid/dout_end) into a parallel digest register and reports completion.
- Sits between a register/bus front end and a bloke2b/bloke2s core instance.

---
 rtl/bloke2_stream_driver.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/bloke2_stream_driver.sv
// bloke2_stream_driver
// Host-side master for the bloke2 hash core byte-stream interface. A message
// is buffered from the host, streamed to the core between start and finish
// pulses, and the core's digest stream is gathered into a parallel register.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data host buffer write port (ignored while busy)
//   go, go_len           hash request and message length, sampled in IDLE
//   busy, done, err      status: busy span, done pulse, error pulse
//   digest               collected digest, byte i at [8*i +: 8]
//   start, finish        one-cycle control pulses to the core
//   din/din_valid/din_ready/din_end  message byte stream to the core
//   dout/dout_valid/dout_end         digest byte stream from the core
module bloke2_stream_driver #(
  parameter int unsigned MAX_LEN      = 64,
  parameter int unsigned LEN_W        = 7,
  parameter int unsigned DIGEST_BYTES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [LEN_W-1:0]          wr_addr,
  input  logic [7:0]                wr_data,
  input  logic                      go,
  input  logic [LEN_W-1:0]          go_len,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [8*DIGEST_BYTES-1:0] digest,
  output logic                      start,
  output logic                      finish,
  output logic [7:0]                din,
  output logic                      din_valid,
  input  logic                      din_ready,
  output logic                      din_end,
  input  logic [7:0]                dout,
  input  logic                      dout_valid,
  input  logic                      dout_end
);

  localparam int unsigned ADDR_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned CNT_W   = $clog2(DIGEST_BYTES + 1);
  localparam int unsigned DBYTE_W = (DIGEST_BYTES > 1) ? $clog2(DIGEST_BYTES) : 1;
  localparam int unsigned DBIT_W  = DBYTE_W + 3;
  localparam int unsigned DIG_W   = 8 * DIGEST_BYTES;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_FEED    = 3'd2;
  localparam logic [2:0] S_FINISH  = 3'd3;
  localparam logic [2:0] S_COLLECT = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]       state_q,     state_d;
  logic [LEN_W-1:0] len_q,       len_d;
  logic [LEN_W-1:0] idx_q,       idx_d;
  logic [CNT_W-1:0] out_cnt_q,   out_cnt_d;
  logic             ovf_q,       ovf_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic             err_q,       err_d;
  logic             start_q,     start_d;
  logic             finish_q,    finish_d;
  logic [7:0]       din_q,       din_d;
  logic             din_valid_q, din_valid_d;
  logic             din_end_q,   din_end_d;
  logic [DIG_W-1:0] digest_q,    digest_d;

  // Message buffer; contents survive reset by design.
  logic [7:0] mem_q [MAX_LEN];

  logic             go_len_ok_c;
  logic [LEN_W-1:0] idx_nxt_c;
  logic [LEN_W-1:0] len_last_c;
  logic [DBIT_W-1:0] dig_lsb_c;
  logic             hs_c;

  assign go_len_ok_c = (go_len != '0) && (go_len <= LEN_W'(MAX_LEN));
  assign idx_nxt_c   = idx_q + LEN_W'(1);
  assign len_last_c  = len_q - LEN_W'(1);
  assign dig_lsb_c   = {DBYTE_W'(out_cnt_q), 3'b000};
  assign hs_c        = din_valid_q && din_ready;

  // Host write port; frozen while a hash is in flight.
  always_ff @(posedge clk) begin
    if (wr_en && !busy_q && (wr_addr < LEN_W'(MAX_LEN))) begin
      mem_q[ADDR_W'(wr_addr)] <= wr_data;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    out_cnt_d   = out_cnt_q;
    ovf_d       = ovf_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    start_d     = 1'b0;
    finish_d    = 1'b0;
    din_d       = din_q;
    din_valid_d = din_valid_q;
    din_end_d   = din_end_q;
    digest_d    = digest_q;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          if (go_len_ok_c) begin
            len_d     = go_len;
            idx_d     = '0;
            out_cnt_d = '0;
            ovf_d     = 1'b0;
            digest_d  = '0;
            busy_d    = 1'b1;
            start_d   = 1'b1;
            state_d   = S_START;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      // Present the first byte as the start pulse retires.
      S_START: begin
        din_valid_d = 1'b1;
        din_d       = mem_q[ADDR_W'(idx_q)];
        din_end_d   = (idx_q == len_last_c);
        state_d     = S_FEED;
      end

      // din/din_end only move on a handshake, so they hold across stalls.
      S_FEED: begin
        if (hs_c) begin
          idx_d = idx_nxt_c;
          if (din_end_q) begin
            din_valid_d = 1'b0;
            din_end_d   = 1'b0;
            finish_d    = 1'b1;
            state_d     = S_FINISH;
          end else begin
            din_d     = mem_q[ADDR_W'(idx_nxt_c)];
            din_end_d = (idx_nxt_c == len_last_c);
          end
        end
      end

      S_FINISH: begin
        state_d = S_COLLECT;
      end

      // Bytes past the digest length are dropped but remembered as overflow.
      S_COLLECT: begin
        if (dout_valid) begin
          if (out_cnt_q < CNT_W'(DIGEST_BYTES)) begin
            digest_d[dig_lsb_c +: 8] = dout;
            out_cnt_d                = out_cnt_q + CNT_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
          if (dout_end) begin
            done_d  = 1'b1;
            err_d   = ovf_q || (out_cnt_q != CNT_W'(DIGEST_BYTES - 1));
            busy_d  = 1'b0;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      out_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
      finish_q    <= 1'b0;
      din_q       <= '0;
      din_valid_q <= 1'b0;
      din_end_q   <= 1'b0;
      digest_q    <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      out_cnt_q   <= out_cnt_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      start_q     <= start_d;
      finish_q    <= finish_d;
      din_q       <= din_d;
      din_valid_q <= din_valid_d;
      din_end_q   <= din_end_d;
      digest_q    <= digest_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign digest    = digest_q;
  assign start     = start_q;
  assign finish    = finish_q;
  assign din       = din_q;
  assign din_valid = din_valid_q;
  assign din_end   = din_end_q;

endmodule
